// File: rtl/divider_16.sv
// divider_16: signed Q(15-FRAC_BITS).FRAC_BITS divider, restoring algorithm, one quotient bit per cycle.
// Optional macro DIVIDER_16_SATURATE_EN clamps overflowing results instead of wrapping.
module divider_16 #(
  parameter int FRAC_BITS = 13
) (
  input  logic        I_CLK,
  input  logic        I_RST_N,
  input  logic        I_VLD,
  input  logic [15:0] I_M1,
  input  logic [15:0] I_M2,
  output logic        O_READY,
  output logic        O_VLD,
  output logic [15:0] O_QUOTIENT
);

  localparam int QW = 16 + FRAC_BITS;
  localparam int CW = $clog2(QW + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [QW-1:0] dq_q, dq_d;
  logic [16:0]   rem_q, rem_d;
  logic [15:0]   div_q, div_d;
  logic          neg_q, neg_d;
  logic          zero_q, zero_d;
  logic          vld_q, vld_d;
  logic [15:0]   quo_q, quo_d;

  logic          accept;
  logic          last;
  logic [17:0]   trial;
  logic [15:0]   mag1;
  logic [15:0]   wrapped;
`ifdef DIVIDER_16_SATURATE_EN
  logic          ovf;
`endif

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (I_VLD) state_d = CALC;
      CALC:    if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    O_READY = (state_q == IDLE);
    accept  = O_READY && I_VLD;
    last    = (state_q == CALC) && (cnt_q == CW'(QW - 1));
  end

  // dq_q shifts dividend bits out of its MSB while quotient bits enter at its LSB
  always_comb begin
    cnt_d   = cnt_q;
    dq_d    = dq_q;
    rem_d   = rem_q;
    div_d   = div_q;
    neg_d   = neg_q;
    zero_d  = zero_q;
    quo_d   = quo_q;
    vld_d   = 1'b0;
    trial   = {rem_q, dq_q[QW-1]};
    mag1    = I_M1[15] ? 16'(-I_M1) : I_M1;
    wrapped = neg_q ? 16'(-dq_q[15:0]) : dq_q[15:0];
`ifdef DIVIDER_16_SATURATE_EN
    ovf     = neg_q ? (dq_q > QW'(32768)) : (dq_q > QW'(32767));
`endif
    if (accept) begin
      cnt_d  = '0;
      dq_d   = QW'(mag1) << FRAC_BITS;
      rem_d  = '0;
      div_d  = I_M2[15] ? 16'(-I_M2) : I_M2;
      neg_d  = I_M1[15] ^ I_M2[15];
      zero_d = (I_M2 == 16'h0000);
    end else if (state_q == CALC) begin
      cnt_d = cnt_q + CW'(1);
      if (trial >= {2'b00, div_q}) begin
        rem_d = 17'(trial - {2'b00, div_q});
        dq_d  = {dq_q[QW-2:0], 1'b1};
      end else begin
        rem_d = trial[16:0];
        dq_d  = {dq_q[QW-2:0], 1'b0};
      end
    end else if (state_q == DONE) begin
      vld_d = 1'b1;
      if (zero_q) quo_d = neg_q ? 16'h8000 : 16'h7FFF;
`ifdef DIVIDER_16_SATURATE_EN
      else if (ovf) quo_d = neg_q ? 16'h8000 : 16'h7FFF;
`endif
      else quo_d = wrapped;
    end
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      cnt_q  <= '0;
      dq_q   <= '0;
      rem_q  <= '0;
      div_q  <= '0;
      neg_q  <= 1'b0;
      zero_q <= 1'b0;
      vld_q  <= 1'b0;
      quo_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      dq_q   <= dq_d;
      rem_q  <= rem_d;
      div_q  <= div_d;
      neg_q  <= neg_d;
      zero_q <= zero_d;
      vld_q  <= vld_d;
      quo_q  <= quo_d;
    end
  end

  assign O_VLD      = vld_q;
  assign O_QUOTIENT = quo_q;

endmodule

// File: tb/tb_divider_16.sv
// tb_divider_16: directed self-checking bench for divider_16 (Q2.13 default).
module tb_divider_16;

  logic        I_CLK = 1'b0;
  logic        I_RST_N;
  logic        I_VLD;
  logic [15:0] I_M1;
  logic [15:0] I_M2;
  logic        O_READY;
  logic        O_VLD;
  logic [15:0] O_QUOTIENT;

  int errors = 0;
  int checks = 0;

  always #5 I_CLK = ~I_CLK;

  divider_16 #(.FRAC_BITS(13)) dut (
    .I_CLK      (I_CLK),
    .I_RST_N    (I_RST_N),
    .I_VLD      (I_VLD),
    .I_M1       (I_M1),
    .I_M2       (I_M2),
    .O_READY    (O_READY),
    .O_VLD      (O_VLD),
    .O_QUOTIENT (O_QUOTIENT)
  );

  // Issues one operand pulse and reports the edge count (after accept) of the first O_VLD, -1 on timeout
  task automatic do_op(input logic [15:0] m1, input logic [15:0] m2,
                       output int lat, output logic [15:0] q);
    @(negedge I_CLK);
    I_VLD = 1'b1;
    I_M1  = m1;
    I_M2  = m2;
    @(posedge I_CLK);
    #1 I_VLD = 1'b0;
    lat = -1;
    q   = 'x;
    for (int i = 1; i <= 60; i++) begin
      @(posedge I_CLK);
      #1;
      if (O_VLD) begin
        lat = i;
        q   = O_QUOTIENT;
        break;
      end
    end
  endtask

  task automatic test_reset();
    I_RST_N = 1'b0;
    I_VLD   = 1'b0;
    I_M1    = 16'h0000;
    I_M2    = 16'h0000;
    #2;
    checks++;
    if (O_READY !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got=%b want=1", O_READY); end
    checks++;
    if (O_VLD !== 1'b0) begin errors++; $display("[TB] FAIL reset_vld got=%b want=0", O_VLD); end
    checks++;
    if (O_QUOTIENT !== 16'h0000) begin errors++; $display("[TB] FAIL reset_quot got=%h want=0000", O_QUOTIENT); end
    repeat (2) @(posedge I_CLK);
    @(negedge I_CLK);
    I_RST_N = 1'b1;
  endtask

  task automatic test_basic();
    int          lat;
    logic [15:0] q;
    do_op(16'h4000, 16'h2000, lat, q);
    checks++;
    if (lat !== 30) begin errors++; $display("[TB] FAIL basic_latency got=%0d want=30", lat); end
    checks++;
    if (q !== 16'h4000) begin errors++; $display("[TB] FAIL basic_quot got=%h want=4000", q); end
    @(posedge I_CLK);
    #1;
    checks++;
    if (O_VLD !== 1'b0) begin errors++; $display("[TB] FAIL basic_vld_pulse got=%b want=0", O_VLD); end
    checks++;
    if (O_READY !== 1'b1) begin errors++; $display("[TB] FAIL basic_ready_after got=%b want=1", O_READY); end
    checks++;
    if (O_QUOTIENT !== 16'h4000) begin errors++; $display("[TB] FAIL basic_hold got=%h want=4000", O_QUOTIENT); end
  endtask

  task automatic test_values();
    logic [15:0] m1  [10] = '{16'h2000, 16'hE000, 16'hF000, 16'h2000, 16'h0001,
                              16'hFFFF, 16'h8000, 16'h2AAA, 16'hD556, 16'h4000};
    logic [15:0] m2  [10] = '{16'h4000, 16'h2000, 16'h2000, 16'hC000, 16'h6000,
                              16'h6000, 16'h2000, 16'h6000, 16'h6000, 16'hE000};
    logic [15:0] exp [10] = '{16'h1000, 16'hE000, 16'hF000, 16'hF000, 16'h0000,
                              16'h0000, 16'h8000, 16'h0E38, 16'hF1C8, 16'hC000};
    int          lat;
    logic [15:0] q;
    for (int i = 0; i < 10; i++) begin
      do_op(m1[i], m2[i], lat, q);
      checks++;
      if (lat !== 30) begin errors++; $display("[TB] FAIL value%0d_latency got=%0d want=30", i, lat); end
      checks++;
      if (q !== exp[i]) begin
        errors++;
        $display("[TB] FAIL value%0d_quot %h/%h got=%h want=%h", i, m1[i], m2[i], q, exp[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] m1  [3] = '{16'h7FFF, 16'h8000, 16'h8000};
    logic [15:0] m2  [3] = '{16'h0001, 16'hE000, 16'h0001};
`ifdef DIVIDER_16_SATURATE_EN
    logic [15:0] exp [3] = '{16'h7FFF, 16'h7FFF, 16'h8000};
`else
    logic [15:0] exp [3] = '{16'hE000, 16'h8000, 16'h0000};
`endif
    int          lat;
    logic [15:0] q;
    for (int i = 0; i < 3; i++) begin
      do_op(m1[i], m2[i], lat, q);
      checks++;
      if (q !== exp[i]) begin
        errors++;
        $display("[TB] FAIL overflow%0d_quot %h/%h got=%h want=%h", i, m1[i], m2[i], q, exp[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int          lat;
    logic [15:0] q;
    do_op(16'h2000, 16'h0000, lat, q);
    checks++;
    if (lat !== 30) begin errors++; $display("[TB] FAIL divzero_pos_latency got=%0d want=30", lat); end
    checks++;
    if (q !== 16'h7FFF) begin errors++; $display("[TB] FAIL divzero_pos_quot got=%h want=7fff", q); end
    do_op(16'hE000, 16'h0000, lat, q);
    checks++;
    if (lat !== 30) begin errors++; $display("[TB] FAIL divzero_neg_latency got=%0d want=30", lat); end
    checks++;
    if (q !== 16'h8000) begin errors++; $display("[TB] FAIL divzero_neg_quot got=%h want=8000", q); end
  endtask

  task automatic test_back_to_back();
    int          pulses;
    int          first;
    logic [15:0] q;
    @(negedge I_CLK);
    I_VLD = 1'b1;
    I_M1  = 16'h4000;
    I_M2  = 16'h2000;
    @(posedge I_CLK);
    #1 I_VLD = 1'b0;
    repeat (4) @(posedge I_CLK);
    @(negedge I_CLK);
    checks++;
    if (O_READY !== 1'b0) begin errors++; $display("[TB] FAIL busy_ready got=%b want=0", O_READY); end
    I_VLD = 1'b1;
    I_M1  = 16'h2000;
    I_M2  = 16'h4000;
    @(posedge I_CLK);
    #1 I_VLD = 1'b0;
    pulses = 0;
    first  = -1;
    q      = 'x;
    for (int k = 6; k <= 45; k++) begin
      @(posedge I_CLK);
      #1;
      if (O_VLD) begin
        pulses++;
        if (first < 0) begin
          first = k;
          q     = O_QUOTIENT;
        end
      end
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("[TB] FAIL busy_pulses got=%0d want=1", pulses); end
    checks++;
    if (first !== 30) begin errors++; $display("[TB] FAIL busy_latency got=%0d want=30", first); end
    checks++;
    if (q !== 16'h4000) begin errors++; $display("[TB] FAIL busy_quot got=%h want=4000", q); end
  endtask

  task automatic test_reset_mid();
    int          lat;
    logic [15:0] q;
    @(negedge I_CLK);
    I_VLD = 1'b1;
    I_M1  = 16'h2000;
    I_M2  = 16'h4000;
    @(posedge I_CLK);
    #1 I_VLD = 1'b0;
    repeat (10) @(posedge I_CLK);
    #1 I_RST_N = 1'b0;
    #1;
    checks++;
    if (O_READY !== 1'b1) begin errors++; $display("[TB] FAIL midreset_ready got=%b want=1", O_READY); end
    checks++;
    if (O_VLD !== 1'b0) begin errors++; $display("[TB] FAIL midreset_vld got=%b want=0", O_VLD); end
    checks++;
    if (O_QUOTIENT !== 16'h0000) begin errors++; $display("[TB] FAIL midreset_quot got=%h want=0000", O_QUOTIENT); end
    repeat (2) @(posedge I_CLK);
    // Release reset and present operands together so the first edge after release accepts them
    @(negedge I_CLK);
    I_RST_N = 1'b1;
    I_VLD   = 1'b1;
    I_M1    = 16'h4000;
    I_M2    = 16'h2000;
    @(posedge I_CLK);
    #1 I_VLD = 1'b0;
    lat = -1;
    q   = 'x;
    for (int i = 1; i <= 60; i++) begin
      @(posedge I_CLK);
      #1;
      if (O_VLD) begin
        lat = i;
        q   = O_QUOTIENT;
        break;
      end
    end
    checks++;
    if (lat !== 30) begin errors++; $display("[TB] FAIL midreset_latency got=%0d want=30", lat); end
    checks++;
    if (q !== 16'h4000) begin errors++; $display("[TB] FAIL midreset_quot_after got=%h want=4000", q); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_overflow();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
